cla_pipe_addsub: RTL
====================

Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry look-ahead adder/subtractor; the next generation of the team's 4-bit-group CLA adders.
- Operand width is split into STAGES equal segments. Each stage resolves one segment with 4-bit CLA groups and a group-level look-ahead, then registers the carry into the next stage.
- Adds add/sub mode, signed overflow and zero flags, and a valid/ready handshake on both sides.
- Sits in the datapath wherever a wide add must close timing at the core clock.

Parameters:
- WIDTH, 64, operand/result width in bits. WIDTH/STAGES must be a multiple of 4.
- STAGES, 4, number of pipeline stages (1..8). This is also the result latency in cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in. Used in add mode only.
- sub  input  1  0 = A+B+cin; 1 = A-B (computed as A + ~B + 1; cin ignored).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB. In sub mode, 1 = no borrow (A >= B unsigned).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (async, rst=1): all pipeline valid bits clear. out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready=1 as soon as reset deasserts.
- Segment width is SEG = WIDTH/STAGES. Stage k (0-based) handles bits [k*SEG +: SEG].
- Within a segment:
  - 4-bit groups produce group generate (G) and propagate (P) signals.
  - Group carries come from look-ahead equations on G/P and the segment carry-in, not from a ripple chain.
  - Segment carry-out = segment G | (segment P & segment carry-in).
- Stage 0 carry-in is (sub ? 1 : cin). B is inverted bitwise when sub=1. Inversion happens at capture.
- Skew and deskew:
  - Operand bits for segment k are delayed k cycles so they meet their carry.
  - Sum bits of segment k are delayed (STAGES-1-k) cycles.
  - All bits of one result therefore emerge together.
  - The sub bit, the valid bit and the MSB operand signs travel with the beat.
- Latency: a beat accepted at edge N appears on out_valid/sum after edge N+STAGES-1 when there is no stall. It is visible in the cycle following edge N+STAGES-1, i.e. STAGES register stages.
- Throughput: one beat per cycle when out_ready=1.
- Handshake:
  - advance = !out_valid | out_ready, and in_ready = advance.
  - The whole pipeline holds when advance=0 (global stall). Bubbles are not collapsed.
  - A beat is accepted on a clock edge where in_valid & in_ready.
  - While stalled, sum, cout, ovf and zero hold stable, and out_valid stays 1 until taken.
  - When advance=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Flags are computed in the final stage, registered with sum:
  - ovf = (a_msb == b_eff_msb) & (sum_msb != a_msb), where b_eff is B after sub inversion.
  - zero is a reduction NOR of the final sum.
- Outputs for a bubble: out_valid=0. sum and the flags may hold their last value; the bench must not check them when out_valid=0.
- Simultaneous events: accepting a new beat and emitting a result in the same cycle is legal and required for full throughput.
- Reset mid-operation: all in-flight beats are discarded immediately (async). No partial result is emitted after reset release.
- STAGES=1: behaves as a single registered WIDTH-bit CLA with the same handshake.

Test Plan:
- Reset check: WIDTH=64, STAGES=4; assert rst mid-stream with 3 beats in flight -> out_valid drops to 0 asynchronously, and no stale beat appears within 8 cycles after release.
- Basic add: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> 4 cycles later sum=0, cout=1, zero=1, ovf=0. This exercises the full carry across every segment boundary.
- Subtract and overflow:
  - a=64'h8000_0000_0000_0000, b=1, sub=1 -> sum=64'h7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
  - a=5, b=7, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
- Throughput: 100 back-to-back random beats with out_ready=1 -> one result per cycle, in order, matching the reference model A+B+cin / A-B mod 2^64 plus flags.
- Backpressure: out_ready held 0 for 5 cycles with the pipe full -> in_ready=0, outputs stable. On release, the 4 queued results drain in order with no loss or duplication.
- Parameter sweep: WIDTH=16/STAGES=1, WIDTH=32/STAGES=2, WIDTH=64/STAGES=8 with cin=1 and random sub -> latency equals STAGES and results match the model.

Source files
------------

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry look-ahead adder/subtractor: one WIDTH/STAGES-bit segment per stage,
// STAGES cycles of latency, whole pipe holds on a global stall (in_ready = !out_valid | out_ready).
module cla_pipe_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / 4;

  // Returns {segment carry-out, segment sum}; group carries are flat look-ahead terms.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [SEG-1:0] g, p, c;
    logic [NG-1:0]  gg, pg;
    logic [NG:0]    gc;
    logic           pp, gt, term;
    g = x & y;
    p = x ^ y;
    c = '0;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      pg[j] = &p[4*j +: 4];
    end
    for (int j = 0; j <= NG; j++) begin
      pp = 1'b1;
      gt = 1'b0;
      for (int i = 0; i < j; i++) begin
        pp   = pp & pg[i];
        term = gg[i];
        for (int m = i + 1; m < j; m++) term = term & pg[m];
        gt = gt | term;
      end
      gc[j] = gt | (pp & ci);
    end
    for (int j = 0; j < NG; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                 (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    return {gc[NG], p ^ c};
  endfunction

  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [STAGES-1:0] c_q, c_d, c_in, v_q, v_d, v_in;
  logic              ovf_q, ovf_d, zero_q, zero_d, advance;
  logic [SEG:0]      seg_r;

  always_comb begin
    advance = !v_q[STAGES-1] | out_ready;
    // Stage 0 sees the port operands with B already inverted for subtract.
    a_in[0] = a;
    b_in[0] = b ^ {WIDTH{sub}};
    s_in[0] = '0;
    c_in[0] = sub | cin;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
    seg_r = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_r  = cla_seg(a_in[k][k*SEG +: SEG], b_in[k][k*SEG +: SEG], c_in[k]);
      s_d[k] = s_in[k];
      s_d[k][k*SEG +: SEG] = seg_r[SEG-1:0];
      c_d[k] = seg_r[SEG];
      a_d[k] = a_in[k];
      b_d[k] = b_in[k];
      v_d[k] = v_in[k];
    end
    ovf_d  = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &
             (s_d[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
    zero_d = ~|s_d[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q    <= '0;
      v_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q    <= c_d;
      v_q    <= v_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
